// File: rtl/lru_refill_ctrl_if.sv
// lru_refill_ctrl_if
//
// Purpose: groups every handshake and bus signal of the miss/refill
// controller into one bundle. Clock and reset are not part of it and stay
// plain module ports.
//
// Signal groups:
//   miss_*      miss request in, miss_ready / miss_done / miss_way out
//   hit_*       hit reference from the tag compare
//   wb_*        writeback request (wb_valid/wb_ready handshake)
//   fill_*      refill request (fill_valid/fill_ready) plus fill_done pulse
//   LRU port    line_selector, lru_update, referenced_set out; lru_way in
//
// Modports:
//   master  the controller (drives requests, miss completion, LRU port)
//   slave   the surrounding cache / memory side
interface lru_refill_ctrl_if #(
    parameter int INDEX_BITS  = 8,
    parameter int OUTPUT_BITS = 2
);
    logic                   miss_valid;
    logic                   miss_ready;
    logic [INDEX_BITS-1:0]  miss_index;
    logic                   miss_write;
    logic                   miss_done;
    logic [OUTPUT_BITS-1:0] miss_way;

    logic                   hit_valid;
    logic [INDEX_BITS-1:0]  hit_index;
    logic [OUTPUT_BITS-1:0] hit_way;
    logic                   hit_write;

    logic                   wb_valid;
    logic                   wb_ready;
    logic [INDEX_BITS-1:0]  wb_index;
    logic [OUTPUT_BITS-1:0] wb_way;

    logic                   fill_valid;
    logic                   fill_ready;
    logic [INDEX_BITS-1:0]  fill_index;
    logic [OUTPUT_BITS-1:0] fill_way;
    logic                   fill_done;

    logic [INDEX_BITS-1:0]  line_selector;
    logic [OUTPUT_BITS-1:0] lru_way;
    logic                   lru_update;
    logic [OUTPUT_BITS-1:0] referenced_set;

    modport master (
        input  miss_valid, miss_index, miss_write,
        input  hit_valid, hit_index, hit_way, hit_write,
        input  wb_ready, fill_ready, fill_done, lru_way,
        output miss_ready, miss_done, miss_way,
        output wb_valid, wb_index, wb_way,
        output fill_valid, fill_index, fill_way,
        output line_selector, lru_update, referenced_set
    );

    modport slave (
        output miss_valid, miss_index, miss_write,
        output hit_valid, hit_index, hit_way, hit_write,
        output wb_ready, fill_ready, fill_done, lru_way,
        input  miss_ready, miss_done, miss_way,
        input  wb_valid, wb_index, wb_way,
        input  fill_valid, fill_index, fill_way,
        input  line_selector, lru_update, referenced_set
    );
endinterface

// File: rtl/lru_refill_ctrl.sv
// lru_refill_ctrl
//
// Purpose: miss/refill controller sitting in front of the LRU replacement
// block. Keeps a valid and a dirty bit per (set, way), chooses a victim way
// for each miss (lowest-numbered invalid way, else the LRU way), runs the
// writeback and refill handshakes for that victim and finally reports the
// installed way to the LRU. Hit references are forwarded to the LRU port
// combinationally so recency tracking stays current, and they always take
// priority over the controller's own use of that port.
//
// Ports:
//   clk    clock, single domain
//   rst_n  asynchronous active-low reset
//   bus    lru_refill_ctrl_if.master - miss, hit, writeback, refill and
//          LRU update signals
module lru_refill_ctrl #(
    parameter int ASSOCIATIVITY = 4,
    parameter int ENTRIES       = 256,
    parameter int INDEX_BITS    = 8,
    parameter int OUTPUT_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lru_refill_ctrl_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        FILL_REQ,
        FILL_WAIT,
        UPDATE
    } state_t;

    state_t                   state_q, state_d;

    logic [INDEX_BITS-1:0]    idx_q, idx_d;
    logic                     write_q, write_d;
    logic [OUTPUT_BITS-1:0]   victim_q, victim_d;

    logic [ASSOCIATIVITY-1:0] valid_q [ENTRIES];
    logic [ASSOCIATIVITY-1:0] dirty_q [ENTRIES];

    logic [ASSOCIATIVITY-1:0] set_valid;
    logic [ASSOCIATIVITY-1:0] set_dirty;
    logic [OUTPUT_BITS-1:0]   pick_way;
    logic                     pick_dirty;

    logic                     fsm_sel;
    logic                     fsm_upd;
    logic                     clr_en;
    logic                     upd_en;
    logic                     miss_ready_c;
    logic                     wb_valid_c;
    logic                     fill_valid_c;
    logic                     miss_done_c;

    // Victim choice for the latched set. The loop runs from the top way down
    // so the last assignment, and therefore the winner, is the lowest invalid
    // way. Only when every way is valid does the LRU suggestion get used.
    always_comb begin
        set_valid = valid_q[idx_q];
        set_dirty = dirty_q[idx_q];
        pick_way  = bus.lru_way;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (!set_valid[w]) begin
                pick_way = OUTPUT_BITS'(w);
            end
        end
        pick_dirty = set_valid[pick_way] & set_dirty[pick_way];
    end

    // State register and miss context (index, store flag, chosen victim).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            write_q  <= 1'b0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            victim_q <= victim_d;
        end
    end

    // Next-state and handshake decode. clr_en fires on the edge that enters
    // FILL_REQ so the victim is already invalid while its refill is pending.
    // A hit in LOOKUP or UPDATE stalls the FSM because both need the LRU port.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        write_d      = write_q;
        victim_d     = victim_q;
        miss_ready_c = 1'b0;
        wb_valid_c   = 1'b0;
        fill_valid_c = 1'b0;
        miss_done_c  = 1'b0;
        fsm_sel      = 1'b0;
        fsm_upd      = 1'b0;
        clr_en       = 1'b0;
        upd_en       = 1'b0;

        case (state_q)
            IDLE: begin
                miss_ready_c = 1'b1;
                if (bus.miss_valid) begin
                    idx_d   = bus.miss_index;
                    write_d = bus.miss_write;
                    state_d = LOOKUP;
                end
            end

            LOOKUP: begin
                if (!bus.hit_valid) begin
                    fsm_sel  = 1'b1;
                    victim_d = pick_way;
                    if (pick_dirty) begin
                        state_d = WB_REQ;
                    end else begin
                        clr_en  = 1'b1;
                        state_d = FILL_REQ;
                    end
                end
            end

            WB_REQ: begin
                wb_valid_c = 1'b1;
                if (bus.wb_ready) begin
                    clr_en  = 1'b1;
                    state_d = FILL_REQ;
                end
            end

            FILL_REQ: begin
                fill_valid_c = 1'b1;
                if (bus.fill_ready) begin
                    state_d = bus.fill_done ? UPDATE : FILL_WAIT;
                end
            end

            FILL_WAIT: begin
                if (bus.fill_done) begin
                    state_d = UPDATE;
                end
            end

            UPDATE: begin
                if (!bus.hit_valid) begin
                    fsm_sel     = 1'b1;
                    fsm_upd     = 1'b1;
                    upd_en      = 1'b1;
                    miss_done_c = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line state. Writes are ordered so the later one wins on a collision:
    // a store hit marks dirty, the victim clear comes next, and the install
    // in UPDATE overrides both (a hit on the in-flight victim is a caller
    // error and must not leave stale state behind).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < ENTRIES; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            if (bus.hit_valid && bus.hit_write) begin
                dirty_q[bus.hit_index][bus.hit_way] <= 1'b1;
            end
            if (clr_en) begin
                valid_q[idx_q][victim_d] <= 1'b0;
                dirty_q[idx_q][victim_d] <= 1'b0;
            end
            if (upd_en) begin
                valid_q[idx_q][victim_q] <= 1'b1;
                dirty_q[idx_q][victim_q] <= write_q;
            end
        end
    end

    // Output drive. The LRU port belongs to the hit path whenever hit_valid
    // is high; fsm_sel/fsm_upd are already suppressed in that case.
    assign bus.miss_ready     = miss_ready_c;
    assign bus.miss_done      = miss_done_c;
    assign bus.miss_way       = victim_q;

    assign bus.wb_valid       = wb_valid_c;
    assign bus.wb_index       = idx_q;
    assign bus.wb_way         = victim_q;

    assign bus.fill_valid     = fill_valid_c;
    assign bus.fill_index     = idx_q;
    assign bus.fill_way       = victim_q;

    assign bus.line_selector  = fsm_sel ? idx_q : bus.hit_index;
    assign bus.lru_update     = bus.hit_valid | fsm_upd;
    assign bus.referenced_set = bus.hit_valid ? bus.hit_way
                              : (fsm_upd ? victim_q : '0);

endmodule

// File: tb/tb_lru_refill_ctrl.sv
// tb_lru_refill_ctrl
//
// Purpose: directed self-checking bench for lru_refill_ctrl. Inputs are
// driven on the falling edge, outputs are sampled 1 time unit later, so
// every observation is away from the active rising edge.
module tb_lru_refill_ctrl;

    localparam int IB = 8;
    localparam int OB = 2;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    lru_refill_ctrl_if #(.INDEX_BITS(IB), .OUTPUT_BITS(OB)) bus ();

    lru_refill_ctrl #(
        .ASSOCIATIVITY(4),
        .ENTRIES(256),
        .INDEX_BITS(IB),
        .OUTPUT_BITS(OB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results captured by run_miss for the calling test to compare.
    logic [OB-1:0] r_way;
    logic [OB-1:0] r_ref;
    logic [OB-1:0] r_fill_way;
    logic [OB-1:0] r_wb_way;
    logic [IB-1:0] r_wb_index;
    logic [IB-1:0] r_sel;
    logic          r_upd;
    logic          r_done;
    logic          r_wb;
    logic          r_ready_accept;
    logic          r_ready_busy;
    int            r_lat;
    int            r_wb_cycles;

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issues one miss from IDLE at the current falling edge and runs the
    // writeback side (wb_ready rises on the wb_hold-th cycle of wb_valid)
    // until miss_done or a 40-cycle budget. Returns one cycle after done.
    task automatic run_miss(input logic [IB-1:0] idx, input logic wr,
                            input logic [OB-1:0] lru, input int wb_hold);
        r_done = 0; r_wb = 0; r_wb_cycles = 0; r_lat = 0;
        r_way = 'x; r_ref = 'x; r_fill_way = 'x; r_wb_way = 'x;
        r_wb_index = 'x; r_sel = 'x; r_upd = 'x;
        bus.lru_way    = lru;
        bus.miss_valid = 1'b1;
        bus.miss_index = idx;
        bus.miss_write = wr;
        #1;
        r_ready_accept = bus.miss_ready;
        next_cycle();
        bus.miss_valid = 1'b0;
        bus.miss_write = 1'b0;
        for (int c = 1; c <= 40 && !r_done; c++) begin
            #1;
            if (c == 1) r_ready_busy = bus.miss_ready;
            if (bus.wb_valid) begin
                r_wb = 1;
                r_wb_cycles++;
                r_wb_index  = bus.wb_index;
                r_wb_way    = bus.wb_way;
                bus.wb_ready = (r_wb_cycles >= wb_hold);
            end else begin
                bus.wb_ready = 1'b0;
            end
            if (bus.fill_valid) r_fill_way = bus.fill_way;
            if (bus.miss_done) begin
                r_done = 1;
                r_lat  = c;
                r_way  = bus.miss_way;
                r_ref  = bus.referenced_set;
                r_upd  = bus.lru_update;
                r_sel  = bus.line_selector;
            end
            next_cycle();
        end
        bus.wb_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests++; if (bus.miss_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_miss_ready: got %b expected 1", bus.miss_ready); end
        tests++; if (bus.wb_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_wb_valid: got %b expected 0", bus.wb_valid); end
        tests++; if (bus.fill_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_fill_valid: got %b expected 0", bus.fill_valid); end
        tests++; if (bus.miss_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_miss_done: got %b expected 0", bus.miss_done); end
        tests++; if (bus.lru_update !== 1'b0) begin fails++; $display("[TB] FAIL reset_lru_update: got %b expected 0", bus.lru_update); end
        tests++; if (bus.miss_way !== 2'd0) begin fails++; $display("[TB] FAIL reset_miss_way: got %0d expected 0", bus.miss_way); end
        tests++; if (bus.referenced_set !== 2'd0) begin fails++; $display("[TB] FAIL reset_referenced_set: got %0d expected 0", bus.referenced_set); end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    // Four back-to-back read misses to set 5 fill ways 0..3 in order even
    // though the LRU suggests way 3 each time.
    task automatic test_fill_order();
        for (int i = 0; i < 4; i++) begin
            run_miss(8'd5, 1'b0, 2'd3, 1);
            tests++; if (r_done !== 1'b1) begin fails++; $display("[TB] FAIL fill%0d_done: got %b expected 1", i, r_done); end
            tests++; if (r_way !== 2'(i)) begin fails++; $display("[TB] FAIL fill%0d_miss_way: got %0d expected %0d", i, r_way, i); end
            tests++; if (r_fill_way !== 2'(i)) begin fails++; $display("[TB] FAIL fill%0d_fill_way: got %0d expected %0d", i, r_fill_way, i); end
            tests++; if (r_wb !== 1'b0) begin fails++; $display("[TB] FAIL fill%0d_no_wb: got %b expected 0", i, r_wb); end
            tests++; if (r_lat != 3) begin fails++; $display("[TB] FAIL fill%0d_latency: got %0d expected 3", i, r_lat); end
            tests++; if (r_upd !== 1'b1 || r_ref !== 2'(i)) begin fails++; $display("[TB] FAIL fill%0d_lru_port: got upd=%b ref=%0d expected upd=1 ref=%0d", i, r_upd, r_ref, i); end
            tests++; if (r_sel !== 8'd5) begin fails++; $display("[TB] FAIL fill%0d_line_selector: got %0d expected 5", i, r_sel); end
            tests++; if (r_ready_accept !== 1'b1 || r_ready_busy !== 1'b0) begin fails++; $display("[TB] FAIL fill%0d_miss_ready: got accept=%b busy=%b expected 1/0", i, r_ready_accept, r_ready_busy); end
        end
    endtask

    task automatic test_clean_victim();
        run_miss(8'd5, 1'b0, 2'd2, 1);
        tests++; if (r_wb !== 1'b0) begin fails++; $display("[TB] FAIL clean_no_wb: got %b expected 0", r_wb); end
        tests++; if (r_fill_way !== 2'd2) begin fails++; $display("[TB] FAIL clean_fill_way: got %0d expected 2", r_fill_way); end
        tests++; if (r_way !== 2'd2) begin fails++; $display("[TB] FAIL clean_miss_way: got %0d expected 2", r_way); end
    endtask

    task automatic test_dirty_writeback();
        bus.hit_valid = 1'b1; bus.hit_index = 8'd5; bus.hit_way = 2'd1; bus.hit_write = 1'b1;
        #1;
        tests++; if (bus.line_selector !== 8'd5 || bus.lru_update !== 1'b1 || bus.referenced_set !== 2'd1) begin fails++; $display("[TB] FAIL hit_lru_port: got sel=%0d upd=%b ref=%0d expected 5/1/1", bus.line_selector, bus.lru_update, bus.referenced_set); end
        next_cycle();
        bus.hit_valid = 1'b0; bus.hit_write = 1'b0; bus.hit_index = 8'd0; bus.hit_way = 2'd0;
        run_miss(8'd5, 1'b0, 2'd1, 3);
        tests++; if (r_wb !== 1'b1 || r_wb_index !== 8'd5 || r_wb_way !== 2'd1) begin fails++; $display("[TB] FAIL wb_request: got wb=%b idx=%0d way=%0d expected 1/5/1", r_wb, r_wb_index, r_wb_way); end
        tests++; if (r_wb_cycles != 3) begin fails++; $display("[TB] FAIL wb_hold_cycles: got %0d expected 3", r_wb_cycles); end
        tests++; if (r_fill_way !== 2'd1 || r_way !== 2'd1) begin fails++; $display("[TB] FAIL wb_fill_way: got fill=%0d miss=%0d expected 1/1", r_fill_way, r_way); end
        tests++; if (r_lat != 6) begin fails++; $display("[TB] FAIL wb_latency: got %0d expected 6", r_lat); end
        // way 1 must be valid again: a miss suggesting way 3 must not reuse it
        run_miss(8'd5, 1'b0, 2'd3, 1);
        tests++; if (r_way !== 2'd3 || r_wb !== 1'b0) begin fails++; $display("[TB] FAIL refilled_valid: got way=%0d wb=%b expected 3/0", r_way, r_wb); end
        // and clean: evicting it again must not write back
        run_miss(8'd5, 1'b0, 2'd1, 1);
        tests++; if (r_way !== 2'd1 || r_wb !== 1'b0) begin fails++; $display("[TB] FAIL refilled_clean: got way=%0d wb=%b expected 1/0", r_way, r_wb); end
    endtask

    task automatic test_hit_stall();
        int lat;
        logic done_seen;
        lat = 0;
        done_seen = 0;
        bus.lru_way = 2'd0;
        bus.miss_valid = 1'b1; bus.miss_index = 8'd5; bus.miss_write = 1'b0;
        next_cycle();
        bus.miss_valid = 1'b0;
        bus.hit_valid = 1'b1; bus.hit_index = 8'd7; bus.hit_way = 2'd2;
        #1;
        tests++; if (bus.line_selector !== 8'd7 || bus.referenced_set !== 2'd2 || bus.lru_update !== 1'b1) begin fails++; $display("[TB] FAIL stall_lookup_port: got sel=%0d ref=%0d upd=%b expected 7/2/1", bus.line_selector, bus.referenced_set, bus.lru_update); end
        next_cycle();
        bus.hit_valid = 1'b0;
        #1;
        tests++; if (bus.fill_valid !== 1'b0 || bus.line_selector !== 8'd5) begin fails++; $display("[TB] FAIL stall_lookup_resume: got fill=%b sel=%0d expected 0/5", bus.fill_valid, bus.line_selector); end
        next_cycle();
        #1;
        tests++; if (bus.fill_valid !== 1'b1 || bus.fill_way !== 2'd0 || bus.fill_index !== 8'd5) begin fails++; $display("[TB] FAIL stall_fill_req: got v=%b way=%0d idx=%0d expected 1/0/5", bus.fill_valid, bus.fill_way, bus.fill_index); end
        next_cycle();
        bus.hit_valid = 1'b1;
        #1;
        tests++; if (bus.miss_done !== 1'b0 || bus.line_selector !== 8'd7 || bus.referenced_set !== 2'd2) begin fails++; $display("[TB] FAIL stall_update_port: got done=%b sel=%0d ref=%0d expected 0/7/2", bus.miss_done, bus.line_selector, bus.referenced_set); end
        next_cycle();
        bus.hit_valid = 1'b0; bus.hit_index = 8'd0; bus.hit_way = 2'd0;
        for (int c = 5; c <= 12 && !done_seen; c++) begin
            #1;
            if (bus.miss_done) begin
                done_seen = 1;
                lat = c;
                tests++; if (bus.miss_way !== 2'd0 || bus.referenced_set !== 2'd0 || bus.line_selector !== 8'd5) begin fails++; $display("[TB] FAIL stall_done_port: got way=%0d ref=%0d sel=%0d expected 0/0/5", bus.miss_way, bus.referenced_set, bus.line_selector); end
            end
            next_cycle();
        end
        tests++; if (lat != 5) begin fails++; $display("[TB] FAIL stall_latency: got %0d expected 5", lat); end
        #1;
        tests++; if (bus.miss_ready !== 1'b1) begin fails++; $display("[TB] FAIL stall_back_idle: got %b expected 1", bus.miss_ready); end
    endtask

    task automatic test_write_miss();
        run_miss(8'd9, 1'b1, 2'd0, 1);
        tests++; if (r_way !== 2'd0 || r_wb !== 1'b0) begin fails++; $display("[TB] FAIL wmiss_first: got way=%0d wb=%b expected 0/0", r_way, r_wb); end
        for (int i = 1; i < 4; i++) begin
            run_miss(8'd9, 1'b0, 2'd0, 1);
            tests++; if (r_way !== 2'(i)) begin fails++; $display("[TB] FAIL wmiss_fill%0d: got %0d expected %0d", i, r_way, i); end
        end
        run_miss(8'd9, 1'b0, 2'd0, 1);
        tests++; if (r_wb !== 1'b1 || r_wb_index !== 8'd9 || r_wb_way !== 2'd0) begin fails++; $display("[TB] FAIL wmiss_writeback: got wb=%b idx=%0d way=%0d expected 1/9/0", r_wb, r_wb_index, r_wb_way); end
        tests++; if (r_lat != 4 || r_way !== 2'd0) begin fails++; $display("[TB] FAIL wmiss_evict: got lat=%0d way=%0d expected 4/0", r_lat, r_way); end
    endtask

    task automatic test_reset_mid();
        int late_done;
        late_done = 0;
        bus.fill_done = 1'b0;
        bus.lru_way = 2'd0;
        bus.miss_valid = 1'b1; bus.miss_index = 8'd11; bus.miss_write = 1'b0;
        next_cycle();
        bus.miss_valid = 1'b0;
        next_cycle();
        #1;
        tests++; if (bus.fill_valid !== 1'b1) begin fails++; $display("[TB] FAIL mid_fill_req: got %b expected 1", bus.fill_valid); end
        next_cycle();
        #1;
        tests++; if (bus.fill_valid !== 1'b0 || bus.miss_done !== 1'b0 || bus.miss_ready !== 1'b0) begin fails++; $display("[TB] FAIL mid_fill_wait: got fill=%b done=%b ready=%b expected 0/0/0", bus.fill_valid, bus.miss_done, bus.miss_ready); end
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.miss_ready !== 1'b1 || bus.fill_valid !== 1'b0 || bus.wb_valid !== 1'b0 || bus.miss_done !== 1'b0 || bus.lru_update !== 1'b0 || bus.miss_way !== 2'd0) begin fails++; $display("[TB] FAIL mid_reset_outputs: got ready=%b fill=%b wb=%b done=%b upd=%b way=%0d expected 1/0/0/0/0/0", bus.miss_ready, bus.fill_valid, bus.wb_valid, bus.miss_done, bus.lru_update, bus.miss_way); end
        next_cycle();
        rst_n = 1'b1;
        bus.fill_done = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (bus.miss_done) late_done++;
            next_cycle();
        end
        tests++; if (late_done != 0) begin fails++; $display("[TB] FAIL mid_no_done: got %0d pulses expected 0", late_done); end
        run_miss(8'd5, 1'b0, 2'd3, 1);
        tests++; if (r_ready_accept !== 1'b1 || r_way !== 2'd0 || r_wb !== 1'b0) begin fails++; $display("[TB] FAIL mid_lines_invalid: got ready=%b way=%0d wb=%b expected 1/0/0", r_ready_accept, r_way, r_wb); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.miss_valid = 1'b0; bus.miss_index = '0; bus.miss_write = 1'b0;
        bus.hit_valid = 1'b0; bus.hit_index = '0; bus.hit_way = '0; bus.hit_write = 1'b0;
        bus.wb_ready = 1'b0; bus.fill_ready = 1'b1; bus.fill_done = 1'b1;
        bus.lru_way = '0;
        @(negedge clk);
        test_reset();
        test_fill_order();
        test_clean_victim();
        test_dirty_writeback();
        test_hit_stall();
        test_write_miss();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
